obi_stream_read_dma: RTL

- Parametrised successor of the single-outstanding read DMA used by the ASCON OBI wrapper.
- Accepts a (byte address, byte length, user tag) command and issues pipelined OBI reads, up to MaxOutstanding in flight.
- Returns data as a valid/ready word stream with per-beat byte enables, last flag and user sideband.
- Adds credit-based buffering, zero-length commands, abort, and sticky bus-error reporting.

---
 rtl/obi_stream_read_dma_pkg.sv | 24 ++
 rtl/obi_stream_read_dma_resp_fifo.sv | 61 ++++++
 rtl/obi_stream_read_dma.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/obi_stream_read_dma_pkg.sv
// Shared types for the OBI stream DMAs.
//   obi_dma_beat_t : one response-FIFO entry {data, be, last} at the default 32-bit width
//   dma_state_e    : controller state encoding
//   DmaMaxLen      : largest byte length a 16-bit length field can express
package obi_stream_read_dma_pkg;

  localparam int DmaDataWidth = 32;
  localparam int DmaBw        = DmaDataWidth / 8;
  localparam int DmaMaxLen    = 65535;

  typedef struct packed {
    logic [DmaDataWidth-1:0] data;
    logic [DmaBw-1:0]        be;
    logic                    last;
  } obi_dma_beat_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_ISSUE,
    DMA_DRAIN,
    DMA_ABORT
  } dma_state_e;

endpackage

// File: rtl/obi_stream_read_dma_resp_fifo.sv
// First-word-fall-through FIFO used to buffer OBI read responses.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : drop all entries (wins over push/pop)
//   push, wdata   : write port
//   pop           : consume head entry
//   rdata, valid  : head entry and its valid flag
//   count         : number of entries held
module dma_resp_fifo #(
  parameter int Width = 37,
  parameter int Depth = 4,
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign do_push = push && (cnt != CW'(Depth));
  assign do_pop  = pop && (cnt != '0);

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/obi_stream_read_dma.sv
// Pipelined OBI read DMA: turns a (byte addr, byte len, user) command into
// up to MaxOutstanding in-flight word reads and returns the data as a
// valid/ready stream with byte enables, last flag and user sideband.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   cmd_*                 : command handshake (addr, len, user)
//   abort_i               : cancel the running command
//   obi_*                 : OBI read master
//   s_*                   : response stream (FWFT from the response FIFO)
//   busy_o, done_o, err_o : status (done is a one-cycle pulse, err is sticky)
module obi_stream_read_dma
  import obi_stream_read_dma_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4,
  parameter int FifoDepth      = 4,
  parameter int LenWidth       = 16,
  parameter int UserWidth      = 6,
  localparam int BW = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [31:0]          cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic [UserWidth-1:0] cmd_user_i,
  input  logic                 abort_i,
  output logic                 obi_req_o,
  output logic [31:0]          obi_addr_o,
  output logic                 obi_we_o,
  output logic [BW-1:0]        obi_be_o,
  input  logic                 obi_gnt_i,
  input  logic                 obi_rvalid_i,
  input  logic [DataWidth-1:0] obi_rdata_i,
  input  logic                 obi_err_i,
  output logic                 s_valid_o,
  input  logic                 s_ready_i,
  output logic [DataWidth-1:0] s_data_o,
  output logic [BW-1:0]        s_be_o,
  output logic                 s_last_o,
  output logic [UserWidth-1:0] s_user_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int OffW = $clog2(BW);
  localparam int BCW  = LenWidth + 1 - OffW;     // beat counter width
  localparam int OW   = $clog2(MaxOutstanding + 1);
  localparam int CW   = $clog2(FifoDepth + 1);
  localparam int SW   = CW + 1;                  // credit sum width

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [BW-1:0]        be;
    logic                 last;
  } beat_t;

  dma_state_e           state, state_n;
  logic [31:0]          addr_q;
  logic [BCW-1:0]       issue_left, resp_left, beats;
  logic [BW-1:0]        last_be_q, cmd_last_be;
  logic [UserWidth-1:0] user_q;
  logic [OW-1:0]        outst;
  logic                 err_q, done_q, abort_pend;
  logic                 accept, gnt_ok, rsp_ok, push, pop, done_n;
  logic [LenWidth:0]    len_rnd;
  logic [OffW-1:0]      rem;
  logic [SW-1:0]        credit;
  logic [CW-1:0]        fifo_count;
  logic                 head_valid;
  beat_t                push_beat, head;

  assign cmd_ready_o = (state == DMA_IDLE) && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  // beats = ceil(len / BW); the extra length bit absorbs the rounding carry
  assign len_rnd = {1'b0, cmd_len_i} + (LenWidth + 1)'(BW - 1);
  assign beats   = len_rnd[LenWidth:OffW];
  assign rem     = cmd_len_i[OffW-1:0];

  always_comb begin
    cmd_last_be = '0;
    for (int i = 0; i < BW; i++) cmd_last_be[i] = (rem == '0) || (OffW'(i) < rem);
  end

  // Slots already promised to in-flight reads count against the FIFO, so a
  // response always finds room. Credit can only shrink while a request
  // waits for its grant, which keeps obi_req_o stable until granted.
  assign credit    = SW'(fifo_count) + SW'(outst);
  assign obi_req_o = (state == DMA_ISSUE) && (issue_left != '0) &&
                     (credit < SW'(FifoDepth)) && (outst < OW'(MaxOutstanding));
  assign gnt_ok    = obi_req_o && obi_gnt_i;
  assign rsp_ok    = obi_rvalid_i && (outst != '0);   // stray rvalid ignored
  assign push      = rsp_ok && (state != DMA_ABORT);

  assign obi_addr_o = addr_q;
  assign obi_we_o   = 1'b0;
  assign obi_be_o   = '1;

  always_comb begin
    push_beat      = '0;
    push_beat.data = obi_rdata_i;
    push_beat.last = (resp_left == BCW'(1));
    push_beat.be   = push_beat.last ? last_be_q : '1;
  end

  dma_resp_fifo #(.Width($bits(beat_t)), .Depth(FifoDepth)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (state == DMA_ABORT),
    .push  (push),
    .wdata (push_beat),
    .pop   (pop),
    .rdata (head),
    .valid (head_valid),
    .count (fifo_count)
  );

  // FIFO contents are stale while aborting; hide them from the stream
  assign s_valid_o = head_valid && (state != DMA_ABORT);
  assign pop       = s_valid_o && s_ready_i;
  assign s_data_o  = s_valid_o ? head.data : '0;
  assign s_be_o    = s_valid_o ? head.be : '0;
  assign s_last_o  = s_valid_o && head.last;
  assign s_user_o  = user_q;

  assign busy_o = (state != DMA_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      DMA_IDLE: begin
        if (accept) begin
          if (cmd_len_i == '0) done_n = 1'b1;
          else                 state_n = DMA_ISSUE;
        end
      end
      DMA_ISSUE: begin
        // an ungranted request must be held, so abort waits for its grant
        if ((abort_i || abort_pend) && !(obi_req_o && !obi_gnt_i)) state_n = DMA_ABORT;
        else if (gnt_ok && (issue_left == BCW'(1)))              state_n = DMA_DRAIN;
      end
      DMA_DRAIN: begin
        if (pop && s_last_o) begin
          state_n = DMA_IDLE;
          done_n  = 1'b1;
        end else if (abort_i) begin
          state_n = DMA_ABORT;
        end
      end
      DMA_ABORT: begin
        if (outst == '0) state_n = DMA_IDLE;
      end
      default: state_n = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= DMA_IDLE;
      done_q     <= 1'b0;
      abort_pend <= 1'b0;
      outst      <= '0;
      addr_q     <= '0;
      issue_left <= '0;
      resp_left  <= '0;
      last_be_q  <= '0;
      user_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      done_q     <= done_n;
      abort_pend <= (state == DMA_ISSUE) && (state_n == DMA_ISSUE) && (abort_i || abort_pend);
      outst      <= outst + OW'(gnt_ok) - OW'(rsp_ok);
      if (accept) begin
        addr_q     <= cmd_addr_i & ~32'(BW - 1);
        issue_left <= beats;
        resp_left  <= beats;
        last_be_q  <= cmd_last_be;
        user_q     <= cmd_user_i;
        err_q      <= 1'b0;
      end else begin
        if (gnt_ok) begin
          addr_q     <= addr_q + 32'(BW);
          issue_left <= issue_left - 1'b1;
        end
        if (rsp_ok) begin
          resp_left <= resp_left - 1'b1;
          if (obi_err_i) err_q <= 1'b1;
        end
      end
    end
  end

endmodule
